baud_gen_frac: RTL and testbench
================================

// Module: baud_gen_frac
// PURPOSE
//  Parametrised successor to the fixed-rate baud generator. Produces oversample, mid-bit and
//  bit ticks from a runtime-programmable integer+fractional divisor. Drives both UART TX
//  (bit_tick) and RX (os_tick/mid_tick, phase-realigned by restart on start-bit detect).
//  Divisor changes are shadowed and applied glitch-free at the next tick boundary.
// PARAMETERS
//  DIV_W    16  width of integer divisor (clk cycles per os_tick)
//  FRAC_W   4   width of fractional divisor (units of 1/2**FRAC_W cycle)
//  OVS      16  os_ticks per bit; even, >=2
//  DEF_INT  326 integer divisor after reset; >=2
//  DEF_FRAC 0   fractional divisor after reset
//  derived: PH_W = $clog2(OVS)
// PORTS
//  clk       in   1       system clock
//  reset     in   1       asynchronous reset, active-high
//  en        in   1       count enable; 0 freezes all state
//  div_int   in   DIV_W   requested integer divisor
//  div_frac  in   FRAC_W  requested fractional divisor
//  cfg_load  in   1       1-cycle strobe: capture div_int/div_frac into shadow
//  restart   in   1       1-cycle strobe: realign phase to zero
//  os_tick   out  1       1-cycle pulse per oversample period
//  mid_tick  out  1       1-cycle pulse, coincides with os_tick making os_phase == OVS/2
//  bit_tick  out  1       1-cycle pulse, coincides with os_tick making os_phase wrap to 0
//  os_phase  out  PH_W    oversample index within current bit
//  cfg_err   out  1       1-cycle pulse: cfg_load rejected (div_int < 2)
// BEHAVIOUR
//  Reset: os_tick=mid_tick=bit_tick=cfg_err=0, os_phase=0, active cfg=DEF_INT/DEF_FRAC,
//   pending=0, acc=0, cnt=DEF_INT-1. Asserting reset mid-operation clears outputs immediately.
//  Period: cnt decrements each cycle with en=1. When en=1 and cnt==0: os_tick=1 next cycle,
//   {carry,acc} <= acc + frac (FRAC_W+1-bit add, acc wraps mod 2**FRAC_W),
//   cnt <= int + carry - 1. Spacing between os_ticks = int or int+1 cycles;
//   over 2**FRAC_W os_ticks, exactly frac extra cycles.
//  First os_tick after reset release with en held 1: registered high on the DEF_INT-th edge.
//  os_phase increments mod OVS on each os_tick (same edge os_tick rises).
//  cfg_load: div_int<2 -> cfg_err=1 next cycle, shadow/pending unchanged. Else shadow<=inputs,
//   pending=1; repeated loads before apply overwrite the shadow (last wins).
//  Apply: pending shadow becomes active at the cnt==0 reload (using new int/frac for the
//   reload); acc is NOT cleared. Current period always completes at old divisor.
//  restart (en ignored): cnt <= int-1 of active cfg (pending applied first, incl. same-cycle
//   cfg_load if valid), acc=0, os_phase=0, no tick emitted that cycle even if cnt==0.
//  en=0: cnt, acc, os_phase frozen; tick outputs 0; cfg_load still captured.
//  Priority: reset > restart > tick reload > hold.
//  All tick outputs registered; never high for more than one consecutive cycle except
//   when int==2 and frac==0 is not possible (min spacing 2).
// TESTING
//  1 DEF_INT=4,FRAC=0,OVS=4, en=1 from reset -> os_tick every 4 cycles; mid_tick on 2nd,
//    bit_tick on 4th os_tick (every 16 cycles); os_phase 1,2,3,0.
//  2 cfg div_int=3,div_frac=4 (FRAC_W=4) -> periods 3,3,3,4 repeating; 16 os_ticks in 52 cycles.
//  3 cfg_load div_int=1 -> cfg_err pulse 1 cycle later; tick spacing stays at prior value.
//  4 cfg_load 8 two cycles into a 4-cycle period -> that tick at 4, following spacing 8.
//  5 restart at os_phase=5, div=4 -> next os_tick exactly 4 cycles later with os_phase=1;
//    en low 10 cycles mid-period -> tick delayed by exactly 10 cycles.
//  6 reset asserted between edges mid-period -> all outputs 0 without waiting for clk;
//    after release, first os_tick at DEF_INT edges.

Source files
------------

// File: rtl/baud_gen_frac.sv
// baud_gen_frac
//   Fractional-N baud tick generator. It counts clk cycles down from a runtime
//   integer divisor. A fractional accumulator stretches some oversample
//   periods by one cycle, so over 2**FRAC_W oversample periods exactly
//   div_frac extra cycles are added. UART TX uses bit_tick. UART RX uses
//   os_tick/mid_tick and pulses restart on start-bit detect to realign the
//   phase.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   en                count enable; low freezes counter, accumulator and phase
//   div_int/div_frac  requested divisor, captured into a shadow by cfg_load
//   cfg_load          strobe: capture divisor (rejected if div_int < 2)
//   restart           strobe: realign phase to zero, reload counter
//   os_tick           one pulse per oversample period
//   mid_tick          os_tick that moves os_phase to OVS/2
//   bit_tick          os_tick that wraps os_phase to 0
//   os_phase          oversample index within the current bit
//   cfg_err           one-cycle pulse when a cfg_load is rejected
module baud_gen_frac #(
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OVS      = 16,
  parameter int DEF_INT  = 326,
  parameter int DEF_FRAC = 0,
  localparam int PH_W    = $clog2(OVS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              cfg_load,
  input  logic              restart,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick,
  output logic [PH_W-1:0]   os_phase,
  output logic              cfg_err
);

  // active divisor, shadow divisor and its pending flag
  logic [DIV_W-1:0]  act_int, sh_int;
  logic [FRAC_W-1:0] act_frac, sh_frac;
  logic              pending;

  logic [DIV_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;

  logic              load_ok;
  logic              fire;
  logic [DIV_W-1:0]  cur_int, rs_int, reload;
  logic [FRAC_W-1:0] cur_frac, rs_frac;
  logic [FRAC_W:0]   sum;
  logic [PH_W-1:0]   ph_nxt;

  always_comb begin
    load_ok  = cfg_load && (div_int >= DIV_W'(2));

    // divisor the next reload will use: a pending shadow wins over active
    cur_int  = pending ? sh_int  : act_int;
    cur_frac = pending ? sh_frac : act_frac;

    // restart also honours a valid cfg_load arriving in the same cycle
    rs_int   = load_ok ? div_int  : cur_int;
    rs_frac  = load_ok ? div_frac : cur_frac;

    // tick when the period ends, unless restart takes the cycle
    fire     = en && (cnt == '0) && !restart;

    // carry out of the fractional add stretches the next period by one
    sum      = {1'b0, acc} + {1'b0, cur_frac};
    reload   = cur_int + DIV_W'(sum[FRAC_W]) - DIV_W'(1);

    ph_nxt   = (os_phase == PH_W'(OVS-1)) ? '0 : os_phase + PH_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
      cfg_err  <= 1'b0;
      os_phase <= '0;
      act_int  <= DIV_W'(DEF_INT);
      act_frac <= FRAC_W'(DEF_FRAC);
      sh_int   <= DIV_W'(DEF_INT);
      sh_frac  <= FRAC_W'(DEF_FRAC);
      pending  <= 1'b0;
      acc      <= '0;
      cnt      <= DIV_W'(DEF_INT - 1);
    end else begin
      os_tick  <= fire;
      mid_tick <= fire && (ph_nxt == PH_W'(OVS/2));
      bit_tick <= fire && (ph_nxt == '0);
      cfg_err  <= cfg_load && !load_ok;

      if (restart) begin
        act_int  <= rs_int;
        act_frac <= rs_frac;
        pending  <= 1'b0;
        cnt      <= rs_int - DIV_W'(1);
        acc      <= '0;
        os_phase <= '0;
        if (load_ok) begin
          sh_int  <= div_int;
          sh_frac <= div_frac;
        end
      end else begin
        if (fire) begin
          // shadow takes effect exactly at the period boundary; acc keeps
          // running so the long-run fractional rate is not disturbed
          act_int  <= cur_int;
          act_frac <= cur_frac;
          pending  <= 1'b0;
          acc      <= sum[FRAC_W-1:0];
          cnt      <= reload;
          os_phase <= ph_nxt;
        end else if (en) begin
          cnt <= cnt - DIV_W'(1);
        end
        // a load in the apply cycle re-arms pending with the newer value
        if (load_ok) begin
          sh_int  <= div_int;
          sh_frac <= div_frac;
          pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
module tb_baud_gen_frac;
  localparam int DIV_W = 16, FRAC_W = 4, OVS = 4, DEF_INT = 4, DEF_FRAC = 0;
  localparam int PH_W = $clog2(OVS);

  logic clk = 1'b0;
  logic reset, en, cfg_load, restart;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic os_tick, mid_tick, bit_tick, cfg_err;
  logic [PH_W-1:0] os_phase;

  baud_gen_frac #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS),
                  .DEF_INT(DEF_INT), .DEF_FRAC(DEF_FRAC)) dut (
    .clk(clk), .reset(reset), .en(en), .div_int(div_int), .div_frac(div_frac),
    .cfg_load(cfg_load), .restart(restart), .os_tick(os_tick), .mid_tick(mid_tick),
    .bit_tick(bit_tick), .os_phase(os_phase), .cfg_err(cfg_err));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // reference model: cycles left in the period, fractional residue, phase
  int m_rem, m_acc, m_ai, m_af, m_si, m_sf, m_ph;
  bit m_pend, m_os, m_mid, m_bit, m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset;
    m_rem = DEF_INT - 1; m_acc = 0; m_ai = DEF_INT; m_af = DEF_FRAC;
    m_si = DEF_INT; m_sf = DEF_FRAC; m_pend = 0; m_ph = 0;
    m_os = 0; m_mid = 0; m_bit = 0; m_err = 0;
  endtask

  task automatic model_edge;
    bit lok;
    int ci, cf, tot;
    lok   = cfg_load && (int'(div_int) >= 2);
    m_err = cfg_load && (int'(div_int) < 2);
    m_os = 0; m_mid = 0; m_bit = 0;
    if (restart) begin
      if (lok) begin ci = div_int; cf = div_frac; end
      else if (m_pend) begin ci = m_si; cf = m_sf; end
      else begin ci = m_ai; cf = m_af; end
      m_ai = ci; m_af = cf; m_pend = 0; m_rem = ci - 1; m_acc = 0; m_ph = 0;
    end else begin
      if (en) begin
        if (m_rem == 0) begin
          if (m_pend) begin m_ai = m_si; m_af = m_sf; m_pend = 0; end
          tot   = m_acc + m_af;
          m_acc = tot % (1 << FRAC_W);
          m_rem = m_ai + tot / (1 << FRAC_W) - 1;
          m_ph  = (m_ph + 1) % OVS;
          m_os  = 1; m_mid = (m_ph == OVS/2); m_bit = (m_ph == 0);
        end else m_rem--;
      end
      if (lok) begin m_si = div_int; m_sf = div_frac; m_pend = 1; end
    end
  endtask

  task automatic compare_all;
    chk("os_tick", os_tick, m_os);
    chk("mid_tick", mid_tick, m_mid);
    chk("bit_tick", bit_tick, m_bit);
    chk("os_phase", os_phase, m_ph);
    chk("cfg_err", cfg_err, m_err);
  endtask

  task automatic step(input bit e, input bit r, input bit l, input int di, input int df);
    en = e; restart = r; cfg_load = l; div_int = DIV_W'(di); div_frac = FRAC_W'(df);
    @(posedge clk);
    if (reset) model_reset(); else model_edge();
    #1 compare_all();
  endtask

  task automatic wait_tick(input string nm, output int cyc);
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      step(1, 0, 0, 0, 0);
      cyc++;
      if (os_tick) return;
    end
    n_chk++; n_fail++;
    $display("FAIL %s: no os_tick within %0d cycles", nm, cyc);
  endtask

  typedef struct {
    bit e, r, l; int di, df;
    bit eos, emid, ebit; int eph; bit eerr;
  } vec_t;
  vec_t tv[20];

  initial begin
    int c, sum;
    // rows 1..16: free-running from reset, os every 4, mid at 2nd, bit at 4th
    for (int k = 1; k <= 16; k++)
      tv[k-1] = '{e:1, r:0, l:0, di:0, df:0, eos:(k % 4 == 0), emid:(k == 8),
                  ebit:(k == 16), eph:(k / 4) % 4, eerr:0};
    // rejected load, spacing unchanged
    tv[16] = '{e:1, r:0, l:1, di:1, df:3, eos:0, emid:0, ebit:0, eph:0, eerr:1};
    tv[17] = '{e:1, r:0, l:0, di:0, df:0, eos:0, emid:0, ebit:0, eph:0, eerr:0};
    tv[18] = '{e:1, r:0, l:0, di:0, df:0, eos:0, emid:0, ebit:0, eph:0, eerr:0};
    tv[19] = '{e:1, r:0, l:0, di:0, df:0, eos:1, emid:0, ebit:0, eph:1, eerr:0};

    reset = 1; en = 0; cfg_load = 0; restart = 0; div_int = '0; div_frac = '0;
    model_reset();
    #1 compare_all();
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 0;

    foreach (tv[i]) begin
      step(tv[i].e, tv[i].r, tv[i].l, tv[i].di, tv[i].df);
      chk("tbl_os", os_tick, tv[i].eos);
      chk("tbl_mid", mid_tick, tv[i].emid);
      chk("tbl_bit", bit_tick, tv[i].ebit);
      chk("tbl_phase", os_phase, tv[i].eph);
      chk("tbl_err", cfg_err, tv[i].eerr);
    end

    // load 8 two cycles into a 4-cycle period
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 8, 0);
    wait_tick("t4_old", c); chk("t4_old_gap", c, 2);
    wait_tick("t4_new", c); chk("t4_new_gap", c, 8);

    // 3 + 4/16 -> 16 ticks in 52 cycles
    step(1, 0, 1, 3, 4);
    wait_tick("t2_apply", c);
    sum = 0;
    for (int i = 0; i < 16; i++) begin wait_tick("t2_run", c); sum += c; end
    chk("t2_16_ticks", sum, 52);

    // restart realigns; en low stretches the period
    step(1, 1, 1, 4, 0);
    for (int i = 0; i < 8 && os_phase != PH_W'(3); i++) wait_tick("t5_seek", c);
    step(1, 1, 0, 0, 0);
    wait_tick("t5_restart", c); chk("t5_gap", c, 4); chk("t5_phase", os_phase, 1);
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0, 0);
    wait_tick("t5_en", c); chk("t5_en_gap", c + 12, 14);

    // async reset between edges while os_tick is high
    wait_tick("t6_pre", c);
    reset = 1;
    #1 model_reset();
    chk("t6_async_os", os_tick, 0);
    compare_all();
    #2 reset = 0;
    wait_tick("t6_first", c); chk("t6_first_gap", c, DEF_INT);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 9), $urandom_range(0, 15));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
